// File: rtl/riscv_pkg.sv
// riscv_pkg: shared RV32 definitions used by the EX-stage M-extension unit.
//   muldiv_op_e    - funct3 encoding of the M-extension operations
//   muldiv_state_e - sequencing states of the iterative multiply/divide unit
//   DIV0_QUOT      - quotient returned for a divide by zero (all ones)
//   SIGNED_MIN     - most negative signed value (1 << (XLEN-1))
package riscv_pkg;

    localparam int XLEN_DEFAULT = 32;

    typedef enum logic [2:0] {
        OP_MUL    = 3'd0,
        OP_MULH   = 3'd1,
        OP_MULHSU = 3'd2,
        OP_MULHU  = 3'd3,
        OP_DIV    = 3'd4,
        OP_DIVU   = 3'd5,
        OP_REM    = 3'd6,
        OP_REMU   = 3'd7
    } muldiv_op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_FIX  = 2'd2,
        ST_DONE = 2'd3
    } muldiv_state_e;

    localparam logic [XLEN_DEFAULT-1:0] DIV0_QUOT  = {XLEN_DEFAULT{1'b1}};
    localparam logic [XLEN_DEFAULT-1:0] SIGNED_MIN = {1'b1, {(XLEN_DEFAULT-1){1'b0}}};

endpackage

// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative RV32M multiply/divide unit sitting in the EX stage.
// Operands are captured on start, processed one radix-2 step per cycle
// (shift-add multiply, restoring divide) on unsigned magnitudes, then sign
// corrected. The pipeline is held through stall until the done cycle.
//
// Ports:
//   clk     in   clock, rising edge
//   rst     in   asynchronous active-low reset
//   start   in   M-extension instruction present in EX
//   op      in   funct3 (MUL..REMU)
//   rs1     in   XLEN-bit first operand / dividend
//   rs2     in   XLEN-bit second operand / divisor
//   rd_in   in   destination register
//   flush   in   abort any in-flight operation
//   stall   out  freeze PC, IF/ID and ID/EX (combinational)
//   busy    out  unit is not idle
//   done    out  one-cycle pulse, result/rd_out valid
//   result  out  registered XLEN-bit result
//   rd_out  out  registered destination register
module muldiv_unit
    import riscv_pkg::*;
#(
    parameter int XLEN = XLEN_DEFAULT
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [2:0]      op,
    input  logic [XLEN-1:0] rs1,
    input  logic [XLEN-1:0] rs2,
    input  logic [4:0]      rd_in,
    input  logic            flush,
    output logic            stall,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] result,
    output logic [4:0]      rd_out
);

    localparam int CW = $clog2(XLEN);
    localparam logic [CW-1:0]   lastStep  = CW'(XLEN - 1);
    localparam logic [XLEN-1:0] allOnes   = {XLEN{1'b1}};
    localparam logic [XLEN-1:0] signedMin = {1'b1, {(XLEN-1){1'b0}}};

    function automatic logic [XLEN-1:0] negIf(input logic neg, input logic [XLEN-1:0] v);
        return neg ? -v : v;
    endfunction

    function automatic logic [2*XLEN-1:0] negIfWide(input logic neg, input logic [2*XLEN-1:0] v);
        return neg ? -v : v;
    endfunction

    muldiv_state_e   state;
    muldiv_op_e      opReg;
    logic [CW-1:0]   count;
    logic [4:0]      rdReg;
    logic            isMul;
    logic            negRes;   // negate product / quotient
    logic            negRem;   // negate remainder (dividend was negative)
    logic [XLEN-1:0] opA;      // multiplicand or divisor magnitude
    logic [XLEN-1:0] accHi;    // product high half / partial remainder
    logic [XLEN-1:0] accLo;    // multiplier bits / dividend bits -> quotient

    // ---------------- operand decode at capture ----------------
    muldiv_op_e      opIn;
    logic            signA, signB, div0, ovf;
    logic [XLEN-1:0] magA, magB, specialRes;

    always_comb begin
        opIn  = muldiv_op_e'(op);
        signA = 1'b0;
        signB = 1'b0;
        case (opIn)
            OP_MULH:        begin signA = rs1[XLEN-1]; signB = rs2[XLEN-1]; end
            OP_MULHSU:      begin signA = rs1[XLEN-1]; end
            OP_DIV, OP_REM: begin signA = rs1[XLEN-1]; signB = rs2[XLEN-1]; end
            default:        ;
        endcase
        magA = negIf(signA, rs1);
        magB = negIf(signB, rs2);
        div0 = op[2] && (rs2 == '0);
        ovf  = (opIn == OP_DIV || opIn == OP_REM) && (rs1 == signedMin) && (rs2 == allOnes);
        // op[1] separates REM/REMU from DIV/DIVU
        if (div0)
            specialRes = op[1] ? rs1 : allOnes;
        else
            specialRes = op[1] ? '0 : signedMin;
    end

    // ---------------- shared adder/subtractor ----------------
    // Multiply adds the multiplicand into the high half; divide subtracts the
    // divisor from the shifted partial remainder. The top bit of the sum is the
    // divide's no-borrow flag.
    logic [XLEN:0]   addA, addB;
    logic [XLEN+1:0] sum;
    logic            noBorrow;

    always_comb begin
        addA     = isMul ? {1'b0, accHi} : {accHi, accLo[XLEN-1]};
        addB     = isMul ? {1'b0, opA} : ~{1'b0, opA};
        sum      = {1'b0, addA} + {1'b0, addB} + {{(XLEN+1){1'b0}}, ~isMul};
        noBorrow = sum[XLEN+1];
    end

    // ---------------- sign correction and result select ----------------
    logic [2*XLEN-1:0] prodFix;
    logic [XLEN-1:0]   fixRes;

    always_comb begin
        prodFix = negIfWide(negRes, {accHi, accLo});
        case (opReg)
            OP_MUL:                     fixRes = prodFix[XLEN-1:0];
            OP_MULH, OP_MULHSU, OP_MULHU: fixRes = prodFix[2*XLEN-1:XLEN];
            OP_DIV, OP_DIVU:            fixRes = negIf(negRes, accLo);
            default:                    fixRes = negIf(negRem, accHi);
        endcase
    end

    assign stall = (state == ST_IDLE && start && !flush) || state == ST_CALC || state == ST_FIX;
    assign busy  = (state != ST_IDLE);

    // ---------------- sequencer and datapath registers ----------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state  <= ST_IDLE;
            opReg  <= OP_MUL;
            count  <= '0;
            rdReg  <= '0;
            isMul  <= 1'b0;
            negRes <= 1'b0;
            negRem <= 1'b0;
            opA    <= '0;
            accHi  <= '0;
            accLo  <= '0;
            done   <= 1'b0;
            result <= '0;
            rd_out <= '0;
        end else if (flush) begin
            state <= ST_IDLE;
            done  <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        opReg  <= opIn;
                        rdReg  <= rd_in;
                        count  <= '0;
                        isMul  <= !op[2];
                        negRes <= signA ^ signB;
                        negRem <= signA;
                        accHi  <= '0;
                        opA    <= op[2] ? magB : magA;
                        accLo  <= op[2] ? magA : magB;
                        if (div0 || ovf) begin
                            result <= specialRes;
                            rd_out <= rd_in;
                            done   <= 1'b1;
                            state  <= ST_DONE;
                        end else begin
                            state <= ST_CALC;
                        end
                    end
                end
                ST_CALC: begin
                    if (isMul) begin
                        if (accLo[0])
                            {accHi, accLo} <= {sum[XLEN:0], accLo[XLEN-1:1]};
                        else
                            {accHi, accLo} <= {1'b0, accHi, accLo[XLEN-1:1]};
                    end else begin
                        accHi <= noBorrow ? sum[XLEN-1:0] : addA[XLEN-1:0];
                        accLo <= {accLo[XLEN-2:0], noBorrow};
                    end
                    count <= count + CW'(1);
                    if (count == lastStep)
                        state <= ST_FIX;
                end
                ST_FIX: begin
                    result <= fixRes;
                    rd_out <= rdReg;
                    done   <= 1'b1;
                    state  <= ST_DONE;
                end
                default: begin
                    done  <= 1'b0;
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_muldiv_unit.sv
module tb_muldiv_unit;
    import riscv_pkg::*;

    localparam int XL = 32;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          start = 1'b0;
    logic [2:0]    op = 3'd0;
    logic [XL-1:0] rs1 = '0;
    logic [XL-1:0] rs2 = '0;
    logic [4:0]    rd_in = '0;
    logic          flush = 1'b0;
    logic          stall, busy, done;
    logic [XL-1:0] result;
    logic [4:0]    rd_out;

    int total = 0;
    int bad   = 0;
    logic [XL-1:0] lastRes = '0;
    logic [4:0]    lastRd  = '0;

    muldiv_unit #(.XLEN(XL)) dut (
        .clk(clk), .rst(rst), .start(start), .op(op), .rs1(rs1), .rs2(rs2),
        .rd_in(rd_in), .flush(flush), .stall(stall), .busy(busy), .done(done),
        .result(result), .rd_out(rd_out)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [XL-1:0] got, input logic [XL-1:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Reference results from plain 64-bit arithmetic.
    function automatic logic [XL-1:0] model(input logic [2:0] o, input logic [XL-1:0] a, input logic [XL-1:0] b);
        longint sa, sb, ub, q;
        logic [63:0] p;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ub = longint'({32'b0, b});
        case (o)
            3'd0: begin p = 64'(sa * sb); return p[31:0]; end
            3'd1: begin p = 64'(sa * sb); return p[63:32]; end
            3'd2: begin p = 64'(sa * ub); return p[63:32]; end
            3'd3: begin p = {32'b0, a} * {32'b0, b}; return p[63:32]; end
            3'd4: begin
                if (b == 0) return DIV0_QUOT;
                if (a == SIGNED_MIN && b == DIV0_QUOT) return SIGNED_MIN;
                q = sa / sb; return q[31:0];
            end
            3'd5: return (b == 0) ? DIV0_QUOT : a / b;
            3'd6: begin
                if (b == 0) return a;
                if (a == SIGNED_MIN && b == DIV0_QUOT) return '0;
                q = sa % sb; return q[31:0];
            end
            default: return (b == 0) ? a : a % b;
        endcase
    endfunction

    function automatic bit isSpecial(input logic [2:0] o, input logic [XL-1:0] a, input logic [XL-1:0] b);
        return (o[2] && b == 0) || ((o == 3'd4 || o == 3'd6) && a == SIGNED_MIN && b == DIV0_QUOT);
    endfunction

    // Entered just after a rising edge with the DUT idle; returns just after
    // the rising edge that follows the done cycle.
    task automatic runOp(input string tag, input logic [2:0] o, input logic [XL-1:0] a,
                         input logic [XL-1:0] b, input logic [4:0] r);
        int lat, stallCnt, expLat;
        logic [XL-1:0] expRes;
        expRes = model(o, a, b);
        expLat = isSpecial(o, a, b) ? 1 : XL + 2;
        op = o; rs1 = a; rs2 = b; rd_in = r; start = 1'b1;
        stallCnt = 0;
        @(negedge clk);
        if (stall) stallCnt++;
        @(posedge clk); #1;
        start = 1'b0;
        rs1 = $urandom; rs2 = $urandom; rd_in = 5'($urandom); op = 3'($urandom);
        for (lat = 1; lat < 100; lat++) begin
            @(negedge clk);
            if (done) break;
            if (stall) stallCnt++;
            @(posedge clk); #1;
        end
        chk({tag, "_doneSeen"}, XL'(done), XL'(1));
        chk({tag, "_res"}, result, expRes);
        chk({tag, "_rd"}, XL'(rd_out), XL'(r));
        chk({tag, "_lat"}, XL'(lat), XL'(expLat));
        chk({tag, "_stallCycles"}, XL'(stallCnt), XL'(expLat));
        chk({tag, "_stallInDone"}, XL'(stall), XL'(0));
        lastRes = expRes;
        lastRd  = r;
        @(posedge clk); #1;
        chk({tag, "_pulse"}, XL'(done), XL'(0));
    endtask

    function automatic logic [XL-1:0] pickOperand();
        case ($urandom_range(0, 7))
            0: return '0;
            1: return 32'd1;
            2: return '1;
            3: return SIGNED_MIN;
            4: return 32'h7FFF_FFFF;
            5: return 32'($urandom_range(0, 20));
            6: return -32'($urandom_range(1, 20));
            default: return $urandom;
        endcase
    endfunction

    initial begin
        bit doneSeen;
        // reset state
        #1;
        chk("rst_stall", XL'(stall), 0);
        chk("rst_busy", XL'(busy), 0);
        chk("rst_done", XL'(done), 0);
        chk("rst_result", result, 0);
        chk("rst_rd", XL'(rd_out), 0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk); #1;

        // directed cases
        runOp("mul7x6",   3'd0, 32'd7, 32'd6, 5'd11);
        runOp("mulh_min", 3'd1, SIGNED_MIN, SIGNED_MIN, 5'd12);
        runOp("mulhu_ff", 3'd3, '1, '1, 5'd13);
        runOp("mulhsu",   3'd2, '1, 32'd2, 5'd14);
        runOp("div_m7",   3'd4, -32'd7, 32'd2, 5'd15);
        runOp("rem_m7",   3'd6, -32'd7, 32'd2, 5'd16);
        runOp("divu",     3'd5, 32'hFFFF_FFF9, 32'd2, 5'd17);
        runOp("remu",     3'd7, 32'hFFFF_FFF9, 32'd2, 5'd18);
        runOp("div0",     3'd4, 32'd5, 32'd0, 5'd19);
        runOp("rem0",     3'd6, 32'd5, 32'd0, 5'd20);
        runOp("divovf",   3'd4, SIGNED_MIN, '1, 5'd21);
        runOp("removf",   3'd6, SIGNED_MIN, '1, 5'd22);

        // flush mid-divide; a second start at cycle 5 must be ignored
        op = 3'd4; rs1 = 32'd100; rs2 = 32'd7; rd_in = 5'd9; start = 1'b1;
        for (int cyc = 1; cyc <= 10; cyc++) begin
            @(posedge clk); #1;
            start = (cyc == 5);
            flush = (cyc == 10);
            if (cyc == 5) begin op = 3'd0; rs1 = 32'd3; rs2 = 32'd3; rd_in = 5'd3; end
        end
        @(posedge clk); #1;
        flush = 1'b0;
        @(negedge clk);
        chk("flush_busy", XL'(busy), 0);
        chk("flush_stall", XL'(stall), 0);
        chk("flush_result", result, lastRes);
        chk("flush_rd", XL'(rd_out), XL'(lastRd));
        doneSeen = 1'b0;
        repeat (40) begin
            @(negedge clk);
            if (done) doneSeen = 1'b1;
        end
        chk("flush_noDone", XL'(doneSeen), 0);
        @(posedge clk); #1;
        runOp("after_flush", 3'd4, 32'd100, 32'd7, 5'd9);

        // start together with flush in idle is dropped
        op = 3'd0; rs1 = 32'd2; rs2 = 32'd2; rd_in = 5'd1; start = 1'b1; flush = 1'b1;
        @(negedge clk);
        chk("sf_stall", XL'(stall), 0);
        @(posedge clk); #1;
        start = 1'b0; flush = 1'b0;
        chk("sf_busy", XL'(busy), 0);

        // randomized operations
        for (int i = 0; i < 40; i++) begin
            logic [2:0] o;
            logic [XL-1:0] a, b;
            o = 3'($urandom);
            a = pickOperand();
            b = pickOperand();
            runOp($sformatf("rnd%0d_op%0d", i, o), o, a, b, 5'($urandom));
        end

        // asynchronous reset mid-calculation
        op = 3'd0; rs1 = 32'd5; rs2 = 32'd5; rd_in = 5'd7; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (10) @(posedge clk);
        #2 rst = 1'b0;
        #1;
        chk("midrst_stall", XL'(stall), 0);
        chk("midrst_busy", XL'(busy), 0);
        chk("midrst_done", XL'(done), 0);
        chk("midrst_result", result, 0);
        chk("midrst_rd", XL'(rd_out), 0);
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        runOp("mul3x3", 3'd0, 32'd3, 32'd3, 5'd4);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1);
    end

endmodule

// File: doc/muldiv_unit.md
# muldiv_unit

Iterative RV32M multiply/divide unit in the EX stage, fed by the ID/EX pipeline register. It captures operands on `start`, computes over multiple cycles (radix-2 shift-add multiply, restoring divide), and holds the pipeline through `stall` until the result is ready. The result and destination register go to the EX/MEM register on the `done` cycle. `flush` aborts an in-flight operation on a control hazard.

## Interface
- `XLEN`, default 32: operand and result width. Iteration count equals `XLEN`.
- `clk`  in  1: single clock, rising edge.
- `rst`  in  1: asynchronous, active-low reset.
- `start`  in  1: M-extension instruction present in EX (`ALUCtr` decode from ID/EX).
- `op`  in  3: funct3. 0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU.
- `rs1`, `rs2`  in  XLEN: operands from ID/EX ReadData1/ReadData2.
- `rd_in`  in  5: destination register.
- `flush`  in  1: control-hazard abort.
- `stall`  out  1: freeze PC, IF/ID and ID/EX.
- `busy`  out  1: state is not IDLE.
- `done`  out  1: one-cycle pulse; `result` and `rd_out` are valid.
- `result`  out  XLEN: registered result.
- `rd_out`  out  5: registered destination.

## Operation
- States:
  - IDLE: `start && !flush` captures `op`, `rd_in`, operand magnitudes and sign flags, and sets count=0.
    - Special case to DONE: divide by zero gives quotient all-ones and remainder = rs1.
    - Special case to DONE: signed overflow (DIV/REM of 0x80000000 by -1) gives quotient 0x80000000 and remainder 0.
    - Otherwise go to CALC.
  - CALC: one radix-2 step per cycle with count+1. After step XLEN-1, go to FIX.
  - FIX: apply sign correction and select the result, then go to DONE.
  - DONE: assert `done`, go to IDLE.
- Multiply:
  - 2·XLEN accumulator; unsigned magnitudes.
  - MUL returns the low half.
  - MULH/MULHSU/MULHU return the high half.
  - Product is negated when the operand signs differ. Sign applies to rs1 for MULHSU and to both operands for MULH.
- Divide:
  - Restoring division on magnitudes.
  - Quotient is negated when the signs differ (DIV).
  - Remainder takes the sign of the dividend (REM).
  - Unsigned ops apply no correction.
- Operands are captured at `start`. Input changes afterwards are ignored.
- `start` is ignored outside IDLE.
- `flush` in any state: next state is IDLE, no `done` pulse, `result` and `rd_out` keep their previous values. `flush` and `start` together in IDLE: `start` is ignored.
- `result` and `rd_out` hold their value until the next `done`.
- Reset values: state IDLE, `stall`=0, `busy`=0, `done`=0, `result`=0, `rd_out`=0, internal accumulators 0. Reset takes effect immediately, including mid-CALC.

## Timing
- Cycle 0 = the cycle `start` is sampled in IDLE.
- Normal path:
  - CALC in cycles 1..XLEN.
  - FIX in cycle XLEN+1.
  - DONE in cycle XLEN+2 (34 cycles for XLEN=32).
- Special path: DONE in cycle 1.
- `stall` is combinational: `(IDLE && start && !flush) || CALC || FIX`. It is low in DONE so the pipeline advances on that edge.
- `busy` = state != IDLE.
- `done` is registered and high for exactly one cycle.
- Throughput: a new `start` is accepted earliest in the cycle after DONE.

## Structure
- Shared package `riscv_pkg`:
  - `muldiv_op_e` (funct3 encoding above).
  - `muldiv_state_e` (IDLE, CALC, FIX, DONE).
  - Constants `DIV0_QUOT`=all-ones and `SIGNED_MIN`=1<<(XLEN-1).
- Single module; no sub-module is natural. The datapath shares one XLEN+1-bit adder/subtractor between multiply and divide.

## Test plan
- MUL 7×6 -> `stall` high cycles 0–33, `done`=1 at cycle 34, `result`=42, `rd_out`=`rd_in`.
- High-half products:
  - MULH 0x80000000×0x80000000 -> 0x40000000.
  - MULHU 0xFFFFFFFF×0xFFFFFFFF -> 0xFFFFFFFE.
  - MULHSU 0xFFFFFFFF×2 -> 0xFFFFFFFF.
- Divide and remainder:
  - DIV -7/2 -> 0xFFFFFFFD.
  - REM -7/2 -> 0xFFFFFFFF.
  - DIVU 0xFFFFFFF9/2 -> 0x7FFFFFFC.
  - REMU 0xFFFFFFF9/2 -> 1.
- Special cases, each with `done` at cycle 1:
  - DIV 5/0 -> 0xFFFFFFFF.
  - REM 5/0 -> 5.
  - DIV 0x80000000/0xFFFFFFFF -> 0x80000000.
  - REM 0x80000000/0xFFFFFFFF -> 0.
- `flush` at cycle 10 of a DIV -> IDLE at cycle 11, no `done`, `stall`=0, `result` unchanged. A following `start` completes normally. `start` raised again at cycle 5 mid-op is ignored.
- `rst` low mid-CALC -> all outputs 0 immediately. After release, MUL 3×3 returns 9 at cycle 34.
